rf_wb_arbiter: RTL and testbench

Round-robin arbiter that shares the register file's single write port (we3/a3/wd3) among NREQ writeback requesters, such as ALU result, load return and CSR/debug write. Each requester uses a valid/ready handshake. The accepted write is registered and driven to the register file one cycle later. The block sits between the writeback sources and the register file. It owns write-port sequencing, x0 write suppression and an optional contention counter.

---
 rtl/rf_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter sharing the register-file write port
// (we3/a3/wd3) among NREQ writeback requesters with valid/ready handshakes.
// The accepted write is registered and presented to the register file one
// cycle after the transfer. Writes to x0 are accepted but never enabled.
// Optional feature macro: RFARB_STALL_CNT_EN (saturating contention counter);
// when undefined, stall_cnt is tied to zero and the port list is unchanged.
module rf_wb_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [AW*NREQ-1:0] req_addr,
  input  logic [DW*NREQ-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic             we3,
  output logic [AW-1:0]    a3,
  output logic [DW-1:0]    wd3,
  output logic [15:0]      stall_cnt
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   gnt_idx;
  logic            found;
  logic [NREQ-1:0] grant;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // Scan from rr_ptr upward (mod NREQ); first valid requester wins.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // One-hot grant, suppressed by freeze and held low during reset.
  always_comb begin
    grant = '0;
    if (found) begin
      grant[gnt_idx] = 1'b1;
    end
    req_ready = (rst_n && !freeze) ? grant : '0;
  end

  assign xfer = found && !freeze;

  // Select the winning requester's address/data and compute the next pointer.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_addr = req_addr[AW*i +: AW];
        sel_data = req_data[DW*i +: DW];
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  // Pointer and registered write port; a3/wd3 hold when idle, we3 pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      we3      <= 1'b0;
      a3       <= '0;
      wd3      <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we3      <= xfer && (sel_addr != '0);
      if (xfer) begin
        a3  <= sel_addr;
        wd3 <= sel_data;
      end
    end
  end

`ifdef RFARB_STALL_CNT_EN
  logic        waiting;
  logic [15:0] stall_q;

  assign waiting = |(req_valid & ~req_ready);

  // Count edges where some requester is held off; saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (waiting && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (NREQ=3, AW=5, DW=32),
// with a small behavioural register file fed by the write port.
module tb_rf_wb_arbiter;

`ifdef RFARB_STALL_CNT_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [15:0] stall_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] rf [32];
  logic        rf_clr = 1'b1;

  rf_wb_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .freeze    (freeze),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Register file: commits on the edge after we3 is presented; x0 stays zero.
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int r = 0; r < 32; r++) rf[r] <= '0;
    end else if (we3 && (a3 != 5'd0)) begin
      rf[a3] <= wd3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]        = v;
    req_addr[5*i +: 5]  = a;
    req_data[32*i +: 32] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    freeze    = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    #1;
    chk("reset_ready", {29'd0, req_ready}, 32'd0);
    chk("reset_we3", {31'd0, we3}, 32'd0);
    chk("reset_a3", {27'd0, a3}, 32'd0);
    chk("reset_wd3", wd3, 32'd0);
    chk("reset_stall", {16'd0, stall_cnt}, 32'd0);
    req_valid = 3'b000;
    tick();
    rf_clr = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single write from requester 1
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("single_ready", {29'd0, req_ready}, 32'b010);
    tick();
    set_req(1, 1'b0, 5'd0, 32'd0);
    chk("single_we3", {31'd0, we3}, 32'd1);
    chk("single_a3", {27'd0, a3}, 32'd5);
    chk("single_wd3", wd3, 32'hDEADBEEF);
    tick();
    chk("single_rf5", rf[5], 32'hDEADBEEF);
    chk("single_we3_drop", {31'd0, we3}, 32'd0);
    chk("single_a3_hold", {27'd0, a3}, 32'd5);

    // x0 write from requester 0: accepted, not enabled
    set_req(0, 1'b1, 5'd0, 32'h12345678);
    #1 chk("x0_ready", {29'd0, req_ready}, 32'b001);
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    chk("x0_we3", {31'd0, we3}, 32'd0);
    chk("x0_wd3", wd3, 32'h12345678);
    tick();
    chk("x0_rf0", rf[0], 32'd0);
    chk("x0_rf5_kept", rf[5], 32'hDEADBEEF);

    // Round-robin from reset, all three continuously valid
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h0000_0A00);
    set_req(1, 1'b1, 5'd2, 32'h0000_0B00);
    set_req(2, 1'b1, 5'd3, 32'h0000_0C00);
    for (int c = 0; c < 6; c++) begin
      #1 chk($sformatf("rr_ready_%0d", c), {29'd0, req_ready}, 32'd1 << (c % 3));
      tick();
      chk($sformatf("rr_we3_%0d", c), {31'd0, we3}, 32'd1);
      chk($sformatf("rr_a3_%0d", c), {27'd0, a3}, 32'(c % 3 + 1));
    end
    req_valid = 3'b000;
    chk("rr_stall", {16'd0, stall_cnt}, StallEn ? 32'd6 : 32'd0);
    tick();
    chk("rr_we3_idle", {31'd0, we3}, 32'd0);

    // Pointer resume: 1 alone, then 0 and 2 together -> 2 first
    set_req(1, 1'b1, 5'd9, 32'h9999_0001);
    #1 chk("resume_r1", {29'd0, req_ready}, 32'b010);
    tick();
    set_req(1, 1'b0, 5'd0, 32'd0);
    set_req(0, 1'b1, 5'd10, 32'hAAAA_0000);
    set_req(2, 1'b1, 5'd11, 32'hBBBB_0000);
    #1 chk("resume_first", {29'd0, req_ready}, 32'b100);
    tick();
    set_req(2, 1'b0, 5'd0, 32'd0);
    chk("resume_a3_first", {27'd0, a3}, 32'd11);
    #1 chk("resume_second", {29'd0, req_ready}, 32'b001);
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    chk("resume_a3_second", {27'd0, a3}, 32'd10);
    chk("resume_wd3_second", wd3, 32'hAAAA_0000);

    // freeze for 3 cycles with requester 2 pending
    do_reset();
    freeze = 1'b1;
    set_req(2, 1'b1, 5'd12, 32'hC0DE_0012);
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("frz_ready_%0d", c), {29'd0, req_ready}, 32'd0);
      tick();
      chk($sformatf("frz_we3_%0d", c), {31'd0, we3}, 32'd0);
    end
    chk("frz_stall", {16'd0, stall_cnt}, StallEn ? 32'd3 : 32'd0);
    freeze = 1'b0;
    #1 chk("frz_release_ready", {29'd0, req_ready}, 32'b100);
    tick();
    set_req(2, 1'b0, 5'd0, 32'd0);
    chk("frz_we3", {31'd0, we3}, 32'd1);
    chk("frz_a3", {27'd0, a3}, 32'd12);
    chk("frz_stall_after", {16'd0, stall_cnt}, StallEn ? 32'd3 : 32'd0);

    // Reset during the output cycle of a write to x7
    tick();
    set_req(1, 1'b1, 5'd7, 32'hA5A5A5A5);
    #1 chk("rst_ready", {29'd0, req_ready}, 32'b010);
    tick();
    set_req(1, 1'b0, 5'd0, 32'd0);
    chk("rst_we3_before", {31'd0, we3}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_we3_async", {31'd0, we3}, 32'd0);
    chk("rst_a3_async", {27'd0, a3}, 32'd0);
    tick();
    chk("rst_rf7", rf[7], 32'd0);
    rst_n = 1'b1;
    set_req(0, 1'b1, 5'd1, 32'h1);
    set_req(1, 1'b1, 5'd2, 32'h2);
    set_req(2, 1'b1, 5'd3, 32'h3);
    #1 chk("rst_priority", {29'd0, req_ready}, 32'b001);
    tick();
    req_valid = 3'b000;
    chk("rst_post_a3", {27'd0, a3}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
